cmp_serial_ctrl: RTL and testbench
==================================

// Module: cmp_serial_ctrl
// PURPOSE
//   Sequential front-end for the 2-bit magnitude comparator slice.
//   - Accepts two WIDTH-bit operands on start.
//   - Feeds them through one 2-bit compare slice, MSB pair first, one pair per cycle.
//   - Accumulates a single gt/eq/lt verdict and pulses done.
//   - Lets a wide compare reuse one small comparator, at the cost of a multi-cycle latency.
// PARAMETERS
//   WIDTH   8   operand width; must be even and >= 2; N = WIDTH/2 slices
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request compare; sampled only when accept is legal
//   a        in   WIDTH  operand A, captured on accepted start
//   b        in   WIDTH  operand B, captured on accepted start
//   busy     out  1      high while state is RUN
//   done     out  1      one-cycle pulse; verdict valid from this cycle on
//   a_gt_b   out  1      A > B (unsigned)
//   a_eq_b   out  1      A == B
//   a_lt_b   out  1      A < B (unsigned)
// BEHAVIOUR
//   Reset
//   - state=IDLE; busy=0, done=0; a_gt_b=a_eq_b=a_lt_b=0; index and operand registers cleared.
//   - Reset mid-RUN aborts the compare: no done, verdict stays cleared.
//   States
//   - IDLE: start=1 -> capture a,b into internal regs; idx=N-1; clear verdict to 000; go RUN.
//   - RUN: compare slice {A[2*idx+1:2*idx], B[2*idx+1:2*idx]} using the 2-bit comparator logic.
//       - Slice unequal: record gt/lt for the first unequal slice only; later slices cannot overwrite it.
//       - idx==0: go DONE. If no slice differed, verdict=eq.
//       - Otherwise: idx decrements.
//   - DONE: done=1 for exactly this cycle.
//       - start=1 -> accept new operands, go RUN.
//       - start=0 -> go IDLE.
//   Start handling
//   - start is ignored while busy.
//   - Operand changes after capture have no effect on the current compare.
//   Verdict
//   - Unsigned compare.
//   - Exactly one of gt/eq/lt is high from done until the next accepted start.
//   - All three are 0 while busy and after reset.
//   Latency (start accepted at cycle 0)
//   - RUN occupies cycles 1..N; done=1 at cycle N+1.
//   - With early exit (see CONFIGURATION): done=1 at cycle k+1, where k is the 1-based MSB-first position
//     of the first unequal slice. Equal operands still give done at cycle N+1.
//   Timing
//   - busy=1 exactly in RUN cycles.
//   - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   CMP_SERIAL_EARLY_EXIT_EN
//   - Defined: RUN jumps to DONE in the cycle after the first unequal slice; remaining slices are skipped.
//   - Undefined: all N slices are always processed.
//   - Either way the verdict is identical; only latency differs.
// TESTING (WIDTH=8, start accepted at cycle 0)
//   1 a=8'hA5, b=8'hA5 -> done@5, a_eq_b=1; busy high cycles 1-4 (both configs).
//   2 a=8'h80, b=8'h7F -> a_gt_b=1; done@2 with EARLY_EXIT_EN, done@5 without.
//   3 a=8'h12, b=8'h13 -> a_lt_b=1, done@5 (both configs).
//   4 start again at cycle 2 with a=8'h00, b=8'hFF during test 1 -> ignored; test 1 result unchanged.
//   5 rst=1 at cycle 3 of test 3 -> no done; all outputs 0 next cycle; state IDLE.
//   6 start held high in done cycle, new a=8'h01, b=8'h00 -> busy next cycle, verdict cleared, later a_gt_b=1.

Source files
------------

// File: rtl/cmp_serial_ctrl.sv
// Serial WIDTH-bit unsigned magnitude compare through one 2-bit slice, MSB pair first.
// Optional: define CMP_SERIAL_EARLY_EXIT_EN to finish right after the first unequal slice.
module cmp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             gt_r, lt_r;

  // Operands shift left each RUN cycle, so the current slice is always the top pair.
  logic [1:0] sa, sb;
  logic       nxt_gt, nxt_lt, last;

  assign sa = a_r[WIDTH-1 -: 2];
  assign sb = b_r[WIDTH-1 -: 2];

  // Once a slice has differed, the recorded direction is frozen.
  always_comb begin
    nxt_gt = gt_r | (~gt_r & ~lt_r & (sa > sb));
    nxt_lt = lt_r | (~gt_r & ~lt_r & (sa < sb));
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    last   = (idx == '0) | nxt_gt | nxt_lt;
`else
    last   = (idx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            idx    <= IW'(N - 1);
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
            a_gt_b <= 1'b0;
            a_eq_b <= 1'b0;
            a_lt_b <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          gt_r <= nxt_gt;
          lt_r <= nxt_lt;
          a_r  <= a_r << 2;
          b_r  <= b_r << 2;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            a_gt_b <= nxt_gt;
            a_lt_b <= nxt_lt;
            a_eq_b <= ~(nxt_gt | nxt_lt);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// Scoreboard bench for cmp_serial_ctrl (WIDTH=8); expected verdict and done cycle queued at issue.
module tb_cmp_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b;
  logic       busy, done, a_gt_b, a_eq_b, a_lt_b;

  cmp_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;

  typedef struct {
    logic [2:0] v;
    int         at;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   tot = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    tot++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, expv);
  endfunction

  // Cycles from start-accept cycle to done; k = 1-based position of first unequal slice.
  function automatic int lat(input int k);
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    return k + 1;
`else
    return 5;
`endif
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk({e.name, "_verdict"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(e.v));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] v,
                       input int l, input string nm, input bit push);
    start = 1'b1;
    a = av;
    b = bv;
    if (push) q.push_back('{v, cyc + l, nm});
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    tick();
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] v;
    int         k;
  } vec_t;

  vec_t vt[6];
  int   t0;

  initial begin
    vt[0] = '{8'hFF, 8'h00, GT, 1};
    vt[1] = '{8'h40, 8'h80, LT, 1};
    vt[2] = '{8'h0C, 8'h08, GT, 3};
    vt[3] = '{8'h00, 8'h00, EQ, 4};
    vt[4] = '{8'h3C, 8'h3D, LT, 4};
    vt[5] = '{8'h01, 8'h03, LT, 4};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    chk("reset_outputs", 32'({busy, done, a_gt_b, a_eq_b, a_lt_b}), 32'd0);
    rst = 1'b0;
    tick();

    // Equal operands, plus an ignored start while busy
    t0 = cyc;
    issue(8'hA5, 8'hA5, EQ, 5, "t1", 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_verdict_clear", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0);
      if (i == 2) begin
        start = 1'b1; a = 8'h00; b = 8'hFF;
      end
      tick();
      start = 1'b0;
    end
    chk("t1_busy_low_at_done", 32'(busy), 32'd0);
    drain();
    chk("t4_verdict_hold", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(EQ));

    issue(8'h80, 8'h7F, GT, lat(1), "t2", 1'b1);
    drain();
    issue(8'h12, 8'h13, LT, 5, "t3", 1'b1);
    drain();

    // Reset in RUN aborts the compare
    issue(8'h12, 8'h13, LT, 5, "t5", 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_outputs_after_rst", 32'({busy, done, a_gt_b, a_eq_b, a_lt_b}), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("t5_idle", 32'({busy, done, a_gt_b, a_eq_b, a_lt_b}), 32'd0);

    // Back-to-back: new start in the done cycle
    t0 = cyc;
    issue(8'h12, 8'h13, LT, 5, "t6a", 1'b1);
    repeat (4) tick();
    chk("t6_done_cycle", 32'(done), 32'd1);
    issue(8'h01, 8'h00, GT, 5, "t6b", 1'b1);
    chk("t6_busy_next", 32'(busy), 32'd1);
    chk("t6_verdict_clear", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'd0);
    drain();

    for (int i = 0; i < 6; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].v, lat(vt[i].k), $sformatf("vec%0d", i), 1'b1);
      drain();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
